// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush, EX forwarding, dmem wait FSM.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic [1:0]            ex_result_src,
    input  logic                  ex_branch_taken,
    input  logic                  mem_valid,
    input  logic                  mem_access,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  flush_wb,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_timeout,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls,
    output logic [31:0]           perf_flushes
);

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_t;

    mem_state_t  state;
    logic [15:0] wait_cnt;
    logic        mem_stall;
    logic        load_use;
    logic        branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            wait_cnt <= 16'd0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (mem_valid && mem_access && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= MEM_IDLE;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt == 16'(MEM_TIMEOUT)) begin
                        state <= MEM_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                MEM_ERR: state <= MEM_ERR;
                default: begin
                    state    <= MEM_IDLE;
                    wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign mem_timeout = (state == MEM_ERR);

    // A pending access that misses in IDLE already holds MEM, so it stalls too.
    assign mem_stall = (state == MEM_WAIT) || (state == MEM_ERR) ||
                       ((state == MEM_IDLE) && mem_valid && mem_access && !dmem_ready);

    assign dmem_req = (state == MEM_WAIT) || ((state == MEM_IDLE) && mem_valid && mem_access);

    assign load_use = (ex_result_src == 2'b01) && ex_reg_write && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign branch = ex_branch_taken && !mem_stall;

    assign stall_if  = mem_stall || (!mem_stall && load_use && !ex_branch_taken);
    assign stall_id  = stall_if;
    assign stall_ex  = mem_stall;
    assign stall_mem = mem_stall;
    assign flush_id  = branch;
    assign flush_ex  = !mem_stall && (ex_branch_taken || load_use);
    assign flush_wb  = mem_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (m_we && (m_rd != '0) && (m_rd == rs))
            return 2'b10;
        else if (w_we && (w_rd != '0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= 32'd0;
            perf_stalls  <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (stall_if)
                perf_stalls <= perf_stalls + 32'd1;
            if (branch)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    assign perf_cycles  = 32'd0;
    assign perf_stalls  = 32'd0;
    assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected output bundles are queued per step and checked before the next edge.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, ex_branch_taken, mem_valid, mem_access;
    logic       mem_reg_write, wb_reg_write, dmem_ready;
    logic [1:0] ex_result_src;
    logic       dmem_req, stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, mem_timeout;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] perf_cycles, perf_stalls, perf_flushes;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic [13:0] exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
        .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_access(mem_access),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
        ex_reg_write = 0; ex_result_src = 2'b00; ex_branch_taken = 0;
        mem_valid = 0; mem_access = 0; mem_reg_write = 0; wb_reg_write = 0;
        dmem_ready = 0;
    endtask

    // Bundle order: dmem_req, stall{if,id,ex,mem}, flush{id,ex,wb}, fwd_a, fwd_b, mem_timeout.
    task automatic step(input string tag, input logic dreq, input logic [3:0] st,
                        input logic [2:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                        input logic to);
        sb_t e;
        sb_t got;
        logic [13:0] obs;
        e.tag = tag;
        e.exp = {dreq, st, fl, fa, fb, to};
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        obs = {dmem_req, stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_wb, fwd_a, fwd_b, mem_timeout};
        compared++;
        assert (obs === got.exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%b expected=%b", got.tag, obs, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        check32("perf_cycles_rst", perf_cycles, 32'd0);
        check32("perf_stalls_rst", perf_stalls, 32'd0);
        check32("perf_flushes_rst", perf_flushes, 32'd0);
        step("reset_idle", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);

        // Load-use hazard on rs2, then cleared
        ex_result_src = 2'b01; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5;
        step("load_use", 0, 4'b1100, 3'b010, 2'b00, 2'b00, 0);
        ex_result_src = 2'b00;
        step("load_use_clear", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
        ex_result_src = 2'b01; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step("load_use_x0", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
        ex_rd = 9; id_rs1 = 9; ex_reg_write = 0;
        step("load_use_nowrite", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
        clear_inputs();

        // Forwarding priority and x0 suppression
        ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
        step("fwd_mem", 0, 4'b0000, 3'b000, 2'b10, 2'b10, 0);
        mem_reg_write = 0;
        step("fwd_wb", 0, 4'b0000, 3'b000, 2'b01, 2'b01, 0);
        ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
        step("fwd_x0", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
        ex_rs1 = 3; ex_rs2 = 7; mem_rd = 3; wb_rd = 7;
        step("fwd_split", 0, 4'b0000, 3'b000, 2'b10, 2'b01, 0);
        clear_inputs();

        // Branch alone, then branch with load-use
        ex_branch_taken = 1;
        step("branch", 0, 4'b0000, 3'b110, 2'b00, 2'b00, 0);
        ex_result_src = 2'b01; ex_reg_write = 1; ex_rd = 4; id_rs1 = 4;
        step("branch_load_use", 0, 4'b0000, 3'b110, 2'b00, 2'b00, 0);
        clear_inputs();

        // Single-cycle hit
        mem_valid = 1; mem_access = 1; dmem_ready = 1;
        step("mem_hit", 1, 4'b0000, 3'b000, 2'b00, 2'b00, 0);

        // Miss: ready low 3 cycles then high; branch/load-use masked while stalled
        dmem_ready = 0;
        step("wait_idle_miss", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        ex_branch_taken = 1;
        ex_result_src = 2'b01; ex_reg_write = 1; ex_rd = 6; id_rs1 = 6;
        step("wait_1_masked", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        step("wait_2_masked", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        dmem_ready = 1;
        step("wait_ready", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        mem_valid = 0; mem_access = 0; dmem_ready = 0;
        step("after_wait_branch", 0, 4'b0000, 3'b110, 2'b00, 2'b00, 0);
        clear_inputs();
        step("idle_again", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);

        // Timeout with MEM_TIMEOUT=4
        mem_valid = 1; mem_access = 1;
        step("to_idle_miss", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        for (int i = 1; i <= 4; i++)
            step($sformatf("to_wait_%0d", i), 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        step("to_err", 0, 4'b1111, 3'b001, 2'b00, 2'b00, 1);
        dmem_ready = 1;
        step("to_err_sticky", 0, 4'b1111, 3'b001, 2'b00, 2'b00, 1);
        clear_inputs();
        do_reset();
        step("to_cleared", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);

        // Perf window: 10 non-reset cycles, 3 stall cycles, 1 branch
        do_reset();
        step("perf_c1", 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
        ex_branch_taken = 1;
        step("perf_branch", 0, 4'b0000, 3'b110, 2'b00, 2'b00, 0);
        ex_branch_taken = 0; mem_valid = 1; mem_access = 1;
        step("perf_miss", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        step("perf_wait", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        dmem_ready = 1;
        step("perf_ready", 1, 4'b1111, 3'b001, 2'b00, 2'b00, 0);
        clear_inputs();
        for (int i = 6; i <= 10; i++)
            step($sformatf("perf_c%0d", i), 0, 4'b0000, 3'b000, 2'b00, 2'b00, 0);
`ifdef PIPE_PERF_CNT_EN
        check32("perf_cycles", perf_cycles, 32'd10);
        check32("perf_stalls", perf_stalls, 32'd3);
        check32("perf_flushes", perf_flushes, 32'd1);
`else
        check32("perf_cycles", perf_cycles, 32'd0);
        check32("perf_stalls", perf_stalls, 32'd0);
        check32("perf_flushes", perf_flushes, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
